// File: rtl/toggle_line_pkg.sv
// Shared definitions for the toggle-coded serial line (receiver and future transmitter).
package toggle_line_pkg;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    DATA,
    PARITY,
    STOP
  } toggle_state_t;

  localparam logic TOGGLE_IDLE_BIT  = 1'b0;
  localparam logic TOGGLE_START_BIT = 1'b1;

endpackage

// File: rtl/toggle_detect.sv
// Recovers the transmitter's t input from its q output: tog = line ^ line_d.
module toggle_detect (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic tog
);

  logic line_d;

  // Delay the line by one edge so a level change shows up as a single-cycle toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) line_d <= 1'b0;
    else        line_d <= line;
  end

  assign tog = line ^ line_d;

endmodule

// File: rtl/toggle_line_rx.sv
// Toggle-coded line receiver: frames start / DATA_W data bits LSB-first /
// optional even parity / stop, and presents words on a valid/ready port.
// Define TOGGLE_RX_PARITY_EN to add the parity bit and a live parity_err.
module toggle_line_rx
  import toggle_line_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  toggle_state_t     state, state_nxt;
  logic              tog;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W:0]   sh_ext;
  logic              last_bit;
  logic              par_bad;

  toggle_detect u_det (
    .clk   (clk),
    .reset (reset),
    .line  (line),
    .tog   (tog)
  );

  assign last_bit = (cnt == CW'(DATA_W - 1));
  // New bit enters at the MSB; after DATA_W shifts bit 0 sits at the LSB.
  assign sh_ext   = {tog, sh};
  assign busy     = (state == DATA) || (state == PARITY) || (state == STOP);

  // State register; ARM gives line_d one edge to settle before toggles count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARM;
    else        state <= state_nxt;
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ARM:    state_nxt = IDLE;
      IDLE:   if (tog == TOGGLE_START_BIT) state_nxt = DATA;
      DATA:   if (last_bit) begin
`ifdef TOGGLE_RX_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = IDLE;
      default: state_nxt = ARM;
    endcase
  end

`ifdef TOGGLE_RX_PARITY_EN
  // Even parity check; mismatch is held until the stop bit decides the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad <= 1'b0;
    end else if (state == IDLE) begin
      par_bad <= 1'b0;
    end else if (state == PARITY) begin
      par_bad <= tog ^ (^sh);
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Datapath: bit counter, shift register, output word and one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      sh         <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef TOGGLE_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef TOGGLE_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: if (tog == TOGGLE_START_BIT) cnt <= '0;
        DATA: begin
          sh <= sh_ext[DATA_W:1];
          if (!last_bit) cnt <= cnt + CW'(1);
        end
        STOP: begin
          if (tog != TOGGLE_IDLE_BIT) begin
            frame_err <= 1'b1;
          end else if (par_bad) begin
`ifdef TOGGLE_RX_PARITY_EN
            parity_err <= 1'b1;
`endif
          end else if (!data_valid || data_ready) begin
            // Old word (if any) is consumed on this same edge, so load over it.
            data       <= sh;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_line_rx.sv
// Directed bench for toggle_line_rx driven by a behavioural T flip-flop.
module tb_toggle_line_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       t = 1'b0;
  logic       q = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       frame_err, parity_err, overrun, busy;

  int errors = 0;
  int checks = 0;

  toggle_line_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .line       (q),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transmitter flip-flop.
  always @(posedge clk) if (t) q <= ~q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one t value to the transmitter for one edge; return 1 unit after it.
  task automatic tick(input logic b);
    @(negedge clk) t = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] w, input logic stop, input logic par);
    tick(1'b1);
    for (int i = 0; i < 8; i++) tick(w[i]);
`ifdef TOGGLE_RX_PARITY_EN
    tick(par);
`endif
    tick(stop);
  endtask

  initial begin
    // Reset state, line held high
    #2;
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    repeat (2) tick(1'b0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      check("idle_busy", busy, 0);
      check("idle_valid", data_valid, 0);
    end

    // Clean frame 0xA5
    frame(8'hA5, 1'b0, 1'b0);
    check("a5_busy_stop", busy, 1);
    tick(1'b0);
    check("a5_data", data, 8'hA5);
    check("a5_valid", data_valid, 1);
    check("a5_ferr", frame_err, 0);
    check("a5_perr", parity_err, 0);
    check("a5_ovr", overrun, 0);
    check("a5_busy", busy, 0);
    data_ready = 1'b1;
    tick(1'b0);
    data_ready = 1'b0;
    check("a5_taken", data_valid, 0);

    // Bad stop bit on 0x3C
    frame(8'h3C, 1'b1, 1'b0);
    tick(1'b0);
    check("3c_ferr", frame_err, 1);
    check("3c_valid", data_valid, 0);
    check("3c_data", data, 8'hA5);
    tick(1'b0);
    check("3c_ferr_pulse", frame_err, 0);
    check("3c_no_restart", busy, 0);

    // Back-to-back 0x11, 0x22 with consumer stalled
    frame(8'h11, 1'b0, 1'b0);
    frame(8'h22, 1'b0, 1'b0);
    check("b2b_valid_mid", data_valid, 1);
    check("b2b_ovr_mid", overrun, 0);
    tick(1'b0);
    check("b2b_ovr", overrun, 1);
    check("b2b_data", data, 8'h11);
    check("b2b_valid", data_valid, 1);
    tick(1'b0);
    check("b2b_ovr_pulse", overrun, 0);
    data_ready = 1'b1;
    tick(1'b0);
    data_ready = 1'b0;
    check("b2b_taken", data_valid, 0);
    check("b2b_data_hold", data, 8'h11);

    // Reset at data bit 4 of 0x7E, then 0x81
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'((8'h7E >> i) & 1));
    check("rst_mid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", data_valid, 0);
    check("rst_mid_data", data, 0);
    repeat (2) tick(1'b0);
    reset = 1'b1;
    repeat (3) tick(1'b0);
    frame(8'h81, 1'b0, 1'b0);
    tick(1'b0);
    check("81_data", data, 8'h81);
    check("81_valid", data_valid, 1);
    check("81_ferr", frame_err, 0);
    check("81_perr", parity_err, 0);
    check("81_ovr", overrun, 0);
    data_ready = 1'b1;
    tick(1'b0);
    data_ready = 1'b0;
    check("81_taken", data_valid, 0);

`ifdef TOGGLE_RX_PARITY_EN
    // 0x01 with parity bit 0 is odd: must be rejected
    frame(8'h01, 1'b0, 1'b0);
    tick(1'b0);
    check("par_perr", parity_err, 1);
    check("par_valid", data_valid, 0);
    check("par_data", data, 8'h81);
    tick(1'b0);
    check("par_perr_pulse", parity_err, 0);
`else
    // Odd-weight word still accepted without parity
    frame(8'h01, 1'b0, 1'b0);
    tick(1'b0);
    check("nopar_perr", parity_err, 0);
    check("nopar_valid", data_valid, 1);
    check("nopar_data", data, 8'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_line_rx.md
# toggle_line_rx

Receive end of the toggle-coded serial line driven by a T flip-flop transmitter. The transmitter's `q` toggles on every clock where its `t` is 1. This block reconstructs `t` as `line ^ line_prev`, frames the recovered bit stream (start, data LSB-first, optional parity, stop) and presents each received word on a valid/ready output with error flags. It sits directly on the `q` net of the flip-flop transmitter, in the same clock domain.

## Interface
- `DATA_W`, default 8: data bits per frame, 1..32.
- `clk`  input  1: clock; all sampling on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `line`  input  1: transmitter flip-flop output `q`.
- `data`  output  DATA_W: last received word; reset 0.
- `data_valid`  output  1: `data` holds an unconsumed word; reset 0.
- `data_ready`  input  1: consumer accepts `data` when `data_valid & data_ready`.
- `frame_err`  output  1: one-cycle pulse when the stop bit is bad; reset 0.
- `parity_err`  output  1: one-cycle pulse when parity is bad; reset 0; tied 0 without the macro.
- `overrun`  output  1: one-cycle pulse when a good word is dropped; reset 0.
- `busy`  output  1: high in START_WAIT-exit through STOP (DATA, PARITY, STOP states); reset 0.

## Operation
- Recovered bit `tog = line ^ line_d`. `line_d` is a register loaded with `line` on every edge. Reset value of `line_d` is 0.
- FSM states:
  - ARM: entered on reset. Loads `line_d` only and ignores `tog`. Moves to IDLE after 1 edge.
  - IDLE: stays while `tog=0`. On `tog=1` (start bit), clears the bit counter and moves to DATA.
  - DATA: shifts `tog` in LSB-first. After DATA_W bits, moves to PARITY if `PARITY_EN` is defined, else to STOP.
  - PARITY: compares `tog` to the XOR of the data bits (even parity) and latches a mismatch. Moves to STOP.
  - STOP: `tog` must be 0. Always moves to IDLE.
- Bit counter width is `$clog2(DATA_W+1)`; counts 0..DATA_W-1 with no wrap.
- Stop-bit handling:
  - Stop bit 0, no parity error: the word is good.
  - Stop bit 1: pulse `frame_err`, discard the word, return to IDLE. The offending toggle is not treated as a new start.
  - Parity error with a good stop: pulse `parity_err` and discard the word.
- Good-word handling:
  - If `data_valid=0`, or the consumer takes the old word on the same edge (`data_ready=1`): load `data` and set `data_valid`.
  - Otherwise: keep the old `data`, drop the new word, pulse `overrun`.
- Handshake: `data_valid` clears on the edge where `data_valid & data_ready`. `data` does not change while `data_valid=1`.
- Idle line: a constant `line` at either level is idle, because the coding is level-independent.
- Reset mid-frame: all state returns to reset values immediately. The partial word is lost. `data_valid` drops to 0.

## Timing
- Edge k samples the start toggle. Data bit i is sampled at edge k+1+i. The stop bit is at edge k+DATA_W+1, or k+DATA_W+2 with parity.
- `data_valid` and the error/overrun pulses are registered and rise immediately after the stop-bit edge. Latency from the stop bit to output is 0 cycles of extra delay.
- Back-to-back frames: a start bit may appear on the edge right after the stop bit. IDLE accepts it with no gap required.
- Outputs are registered; there are no combinational paths from `line` or `data_ready` to any output.

## Configuration
- `TOGGLE_RX_PARITY_EN` defined:
  - PARITY state is present.
  - Frame length is DATA_W+3 bits.
  - `parity_err` is live.
- Not defined:
  - No PARITY state.
  - Frame length is DATA_W+2 bits.
  - `parity_err` is constant 0.

## Structure
- Package `toggle_line_pkg` holds:
  - the state enum (`ARM, IDLE, DATA, PARITY, STOP`);
  - constant `TOGGLE_IDLE_BIT = 1'b0`;
  - constant `TOGGLE_START_BIT = 1'b1`.
- The package is shared with the future transmitter.
- Sub-module `toggle_detect` (`clk`, `reset`, `line`, `tog`) holds `line_d` and the XOR. The FSM, shift register, counter and output stage stay in `toggle_line_rx`.

## Test plan
All cases use DATA_W=8 and a behavioural T flip-flop model driving `line`.
- Reset release with `line=1` held, no toggles → no start is detected; `busy=0`, `data_valid=0` for 20 cycles.
- Frame with start, 0xA5 LSB-first, stop (plus parity bit 0 if enabled) → after the stop edge: `data=8'hA5`, `data_valid=1`, no error pulses.
- Frame 0x3C with stop toggle 1 → `frame_err` pulses for 1 cycle; `data_valid` stays 0; `data` keeps its previous value.
- `data_ready=0`, frames 0x11 then 0x22 back-to-back → `data=8'h11` held; `overrun` pulses once after the second stop. Then `data_ready=1` for 1 cycle → `data_valid` falls.
- Reset asserted at data bit 4 of 0x7E, then a clean frame 0x81 → only 0x81 is delivered; no error pulses.
- With the macro: frame 0x01 with parity bit 0 → `parity_err` pulses; `data_valid` stays 0.
